mips_multicycle_control: RTL and testbench
==========================================

# mips_multicycle_control

Multi-cycle MIPS main control FSM. It sequences the shared datapath (single memory, single ALU, PC/IR/ALUOut registers) through fetch, decode, execute, memory and write-back. On every cycle it drives the 3-bit `alu_op` consumed by the ALU control decoder, using that decoder's encoding: 000 add (lw/sw/addi), 001 sub (beq), 010 R-type funct, 011 and (andi), 100 or (ori). It sits between the instruction register and the datapath mux/enable controls.

## Interface
Parameters:
- none (encodings fixed by ISA)

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `opcode`  in  6  IR[31:26]; valid from DECODE until next FETCH completes
- `mem_ready`  in  1  memory access complete this cycle (used only with `MC_MEM_WAIT_EN`)
- `pc_write`  out  1  unconditional PC load
- `pc_write_cond`  out  1  PC load if ALU zero
- `pc_source`  out  2  00 ALU result, 01 ALUOut, 10 jump target
- `i_or_d`  out  1  memory address: 0 PC, 1 ALUOut
- `mem_read`  out  1  memory read strobe
- `mem_write`  out  1  memory write strobe
- `ir_write`  out  1  load IR from memory data
- `reg_dst`  out  1  write register: 0 rt, 1 rd
- `mem_to_reg`  out  1  write data: 0 ALUOut, 1 MDR
- `reg_write`  out  1  register file write enable
- `alu_src_a`  out  1  0 PC, 1 register A
- `alu_src_b`  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- `zero_ext`  out  1  force zero-extension of immediate (andi/ori)
- `alu_op`  out  3  to ALU control decoder
- `instr_done`  out  1  one-cycle pulse on last cycle of each instruction
- `illegal_op`  out  1  one-cycle pulse on undecodable opcode
- `state`  out  4  current state, debug

## Operation
- Moore FSM, 4-bit state register. All outputs are decoded from `state` only, except the `mem_ready` gating described under MC_MEM_WAIT_EN. Any output not listed for a state is 0.
- IDLE (15): all outputs 0 → FETCH.
- FETCH (0): mem_read, ir_write, pc_write, alu_src_b=01, alu_op=000 → DECODE.
- DECODE (1): alu_src_b=11, alu_op=000. Dispatch on `opcode`:
  - 100011/101011 → MEMADR
  - 000000 → EXEC
  - 000100 → BRANCH
  - 001000/001100/001101 → IEXEC
  - 000010 → JUMP
  - other → FETCH, with illegal_op=1 and instr_done=1 in DECODE
- MEMADR (2): alu_src_a=1, alu_src_b=10, alu_op=000 → MEMRD if opcode=100011, else MEMWR.
- MEMRD (3): mem_read, i_or_d=1 → MEMWB.
- MEMWB (4): reg_write, mem_to_reg=1, instr_done → FETCH.
- MEMWR (5): mem_write, i_or_d=1, instr_done → FETCH.
- EXEC (6): alu_src_a=1, alu_src_b=00, alu_op=010 → RWB.
- RWB (7): reg_write, reg_dst=1, instr_done → FETCH.
- BRANCH (8): alu_src_a=1, alu_src_b=00, alu_op=001, pc_write_cond, pc_source=01, instr_done → FETCH.
- IEXEC (9): alu_src_a=1, alu_src_b=10; addi alu_op=000, andi 011 with zero_ext=1, ori 100 with zero_ext=1 → IWB.
- IWB (10): reg_write, reg_dst=0, mem_to_reg=0, instr_done → FETCH.
- JUMP (11): pc_write, pc_source=10, instr_done → FETCH.
- Unused encodings 12–14 → IDLE, all outputs 0.

## Timing
- Reset: async entry to IDLE. All outputs 0 and `state`=4'hF while `rst_n`=0 and for the first cycle after release. FETCH is the second cycle after release.
- Latency with no wait states:
  - lw 5 cycles
  - sw, R-type, addi, andi, ori 4 cycles
  - beq, j 3 cycles
  - illegal opcode 2 cycles
- Back-to-back instructions: FETCH immediately follows the last state; no idle gap.
- Reset asserted mid-instruction aborts it; no further strobes after the reset edge.

## Configuration
- `MC_MEM_WAIT_EN` defined: FETCH, MEMRD and MEMWR hold while `mem_ready`=0.
  - mem_read/mem_write and address selects stay asserted during the hold.
  - pc_write and ir_write in FETCH, and instr_done in MEMWR, are ANDed with `mem_ready`.
  - The state advances only on the cycle `mem_ready`=1.
- `MC_MEM_WAIT_EN` undefined: `mem_ready` is ignored and each memory state lasts exactly one cycle.

## Test plan
- Reset release, opcode=000000 → `state` IDLE(15) → FETCH(0) → DECODE(1) → EXEC(6) with alu_op=010 → RWB(7) with reg_write=1, reg_dst=1, instr_done=1.
- lw (100011) then sw (101011) back-to-back → states 0,1,2,3,4,0,1,2,5. mem_to_reg=1 only in state 4; mem_write=1 only in state 5.
- beq (000100) → BRANCH with alu_op=001, pc_write_cond=1, pc_source=01. andi (001100) → IEXEC with alu_op=011, zero_ext=1. ori (001101) → alu_op=100.
- opcode=111111 → DECODE with illegal_op=1 and instr_done=1, then FETCH. No reg_write or mem_write at any point.
- With `MC_MEM_WAIT_EN`, mem_ready low 3 cycles in FETCH → mem_read held 4 cycles; ir_write and pc_write high only in the 4th cycle.
- rst_n pulsed low during MEMRD → outputs 0 immediately, IDLE, then FETCH. No reg_write from the aborted lw.

Source files
------------

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS main control FSM: fetch/decode/execute/memory/write-back sequencing.
// Optional macro MC_MEM_WAIT_EN stretches FETCH/MEMRD/MEMWR until mem_ready is high.
module mips_multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       zero_ext,
  output logic [2:0] alu_op,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_RWB   = 4'd7,
    S_BRANCH = 4'd8,  S_IEXEC  = 4'd9,  S_IWB    = 4'd10, S_JUMP  = 4'd11,
    S_IDLE   = 4'd15
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       zero_ext;
    logic [2:0] alu_op;
    logic       instr_done;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_t r_state;
  state_t w_next;
  ctrl_t  r_ctrl;
  logic   w_op_legal;
  logic   w_illegal;
  logic   w_fetch_gate;
  logic   w_memwr_gate;

  // Control word for a given state; the opcode only matters for IEXEC ALU selection.
  function automatic ctrl_t decode_ctrl(input state_t s, input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:  begin c.mem_read = 1'b1; c.ir_write = 1'b1; c.pc_write = 1'b1; c.alu_src_b = 2'b01; end
      S_DECODE: c.alu_src_b = 2'b11;
      S_MEMADR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_MEMRD:  begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
      S_MEMWB:  begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; c.instr_done = 1'b1; end
      S_MEMWR:  begin c.mem_write = 1'b1; c.i_or_d = 1'b1; c.instr_done = 1'b1; end
      S_EXEC:   begin c.alu_src_a = 1'b1; c.alu_op = 3'b010; end
      S_RWB:    begin c.reg_write = 1'b1; c.reg_dst = 1'b1; c.instr_done = 1'b1; end
      S_BRANCH: begin
        c.alu_src_a = 1'b1; c.alu_op = 3'b001; c.pc_write_cond = 1'b1;
        c.pc_source = 2'b01; c.instr_done = 1'b1;
      end
      S_IEXEC:  begin
        c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
        case (op)
          OP_ANDI: begin c.alu_op = 3'b011; c.zero_ext = 1'b1; end
          OP_ORI:  begin c.alu_op = 3'b100; c.zero_ext = 1'b1; end
          default: c.alu_op = 3'b000;
        endcase
      end
      S_IWB:    begin c.reg_write = 1'b1; c.instr_done = 1'b1; end
      S_JUMP:   begin c.pc_write = 1'b1; c.pc_source = 2'b10; c.instr_done = 1'b1; end
      default:  c = '0;
    endcase
    return c;
  endfunction

  // Opcode legality check used for DECODE dispatch and the illegal pulse.
  always_comb begin
    case (opcode)
      OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW: w_op_legal = 1'b1;
      default: w_op_legal = 1'b0;
    endcase
  end

`ifdef MC_MEM_WAIT_EN
  assign w_fetch_gate = (r_state != S_FETCH) | mem_ready;
  assign w_memwr_gate = (r_state != S_MEMWR) | mem_ready;
`else
  assign w_fetch_gate = mem_ready | 1'b1;
  assign w_memwr_gate = 1'b1;
`endif

  // Next-state selection; memory states hold on w_fetch/memwr gating when wait states are enabled.
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:   w_next = S_FETCH;
`ifdef MC_MEM_WAIT_EN
      S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
      S_MEMRD:  w_next = mem_ready ? S_MEMWB  : S_MEMRD;
      S_MEMWR:  w_next = mem_ready ? S_FETCH  : S_MEMWR;
`else
      S_FETCH:  w_next = S_DECODE;
      S_MEMRD:  w_next = S_MEMWB;
      S_MEMWR:  w_next = S_FETCH;
`endif
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:             w_next = S_MEMADR;
          OP_RTYPE:                 w_next = S_EXEC;
          OP_BEQ:                   w_next = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI: w_next = S_IEXEC;
          OP_J:                     w_next = S_JUMP;
          default:                  w_next = S_FETCH;
        endcase
      end
      S_MEMADR: w_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMWB, S_RWB, S_BRANCH, S_IWB, S_JUMP: w_next = S_FETCH;
      S_EXEC:   w_next = S_RWB;
      S_IEXEC:  w_next = S_IWB;
      default:  w_next = S_IDLE;
    endcase
  end

  // State register with the control word pre-decoded for the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ctrl  <= '0;
    end else begin
      r_state <= w_next;
      r_ctrl  <= decode_ctrl(w_next, opcode);
    end
  end

  // Opcode is only valid once DECODE is reached, so the illegal pulse is decoded live.
  assign w_illegal     = (r_state == S_DECODE) & ~w_op_legal;

  assign pc_write      = r_ctrl.pc_write & w_fetch_gate;
  assign pc_write_cond = r_ctrl.pc_write_cond;
  assign pc_source     = r_ctrl.pc_source;
  assign i_or_d        = r_ctrl.i_or_d;
  assign mem_read      = r_ctrl.mem_read;
  assign mem_write     = r_ctrl.mem_write;
  assign ir_write      = r_ctrl.ir_write & w_fetch_gate;
  assign reg_dst       = r_ctrl.reg_dst;
  assign mem_to_reg    = r_ctrl.mem_to_reg;
  assign reg_write     = r_ctrl.reg_write;
  assign alu_src_a     = r_ctrl.alu_src_a;
  assign alu_src_b     = r_ctrl.alu_src_b;
  assign zero_ext      = r_ctrl.zero_ext;
  assign alu_op        = r_ctrl.alu_op;
  assign instr_done    = (r_ctrl.instr_done & w_memwr_gate) | w_illegal;
  assign illegal_op    = w_illegal;
  assign state         = r_state;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench for mips_multicycle_control: per-opcode state paths and control words.
module tb_mips_multicycle_control;
  logic       clk, rst_n, mem_ready;
  logic [5:0] opcode;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a, zero_ext, instr_done, illegal_op;
  logic [1:0] pc_source, alu_src_b;
  logic [2:0] alu_op;
  logic [3:0] state;
  logic [19:0] act;

  int checks = 0;
  int failures = 0;
  int exp_q[$];

  mips_multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .zero_ext(zero_ext), .alu_op(alu_op),
    .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
  );

  assign act = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
                reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, zero_ext, alu_op,
                instr_done, illegal_op};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {6'b000000, 6'b000010, 6'b000100, 6'b001000,
                      6'b001100, 6'b001101, 6'b100011, 6'b101011};
  endfunction

  // Expected sequence of states visited by one instruction, starting at FETCH.
  function automatic void make_path(input logic [5:0] op);
    exp_q = '{0, 1};
    case (op)
      6'b100011: exp_q = {exp_q, 2, 3, 4};
      6'b101011: exp_q = {exp_q, 2, 5};
      6'b000000: exp_q = {exp_q, 6, 7};
      6'b000100: exp_q.push_back(8);
      6'b001000, 6'b001100, 6'b001101: exp_q = {exp_q, 9, 10};
      6'b000010: exp_q.push_back(11);
      default: ;
    endcase
  endfunction

  function automatic logic [19:0] exp_vec(input int st, input logic [5:0] op);
    logic pw, pwc, iod, mr, mw, irw, rd, m2r, rw, sa, ze, done, ill;
    logic [1:0] ps, sb;
    logic [2:0] aop;
    {pw, pwc, iod, mr, mw, irw, rd, m2r, rw, sa, ze, done, ill} = 13'd0;
    ps = 2'd0; sb = 2'd0; aop = 3'd0;
    case (st)
      0:  begin mr = 1'b1; irw = 1'b1; pw = 1'b1; sb = 2'b01; end
      1:  begin sb = 2'b11; if (!is_legal(op)) begin ill = 1'b1; done = 1'b1; end end
      2:  begin sa = 1'b1; sb = 2'b10; end
      3:  begin mr = 1'b1; iod = 1'b1; end
      4:  begin rw = 1'b1; m2r = 1'b1; done = 1'b1; end
      5:  begin mw = 1'b1; iod = 1'b1; done = 1'b1; end
      6:  begin sa = 1'b1; aop = 3'b010; end
      7:  begin rw = 1'b1; rd = 1'b1; done = 1'b1; end
      8:  begin sa = 1'b1; aop = 3'b001; pwc = 1'b1; ps = 2'b01; done = 1'b1; end
      9:  begin
            sa = 1'b1; sb = 2'b10;
            if (op == 6'b001100) begin aop = 3'b011; ze = 1'b1; end
            else if (op == 6'b001101) begin aop = 3'b100; ze = 1'b1; end
          end
      10: begin rw = 1'b1; done = 1'b1; end
      11: begin pw = 1'b1; ps = 2'b10; done = 1'b1; end
      default: ;
    endcase
    return {pw, pwc, ps, iod, mr, mw, irw, rd, m2r, rw, sa, sb, ze, aop, done, ill};
  endfunction

  // Runs one instruction from FETCH; entered and left #1 after a rising edge in FETCH.
  task automatic run_instr(input logic [5:0] op, input string tag);
    int st;
    logic [19:0] e;
    make_path(op);
    opcode = op;
    for (int i = 0; i < exp_q.size(); i++) begin
      st = exp_q[i];
      e = exp_vec(st, op);
      @(negedge clk);
      checks++;
      if (state !== st[3:0] || act !== e) begin
        failures++;
        $display("FAIL %s op=%b step%0d: state=%0d ctrl=%h expected state=%0d ctrl=%h",
                 tag, op, i, state, act, st, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; opcode = 6'd0; mem_ready = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    checks++;
    if (state !== 4'hF || act !== 20'd0) begin
      failures++;
      $display("FAIL reset_hold: state=%0d ctrl=%h expected state=15 ctrl=0", state, act);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (state !== 4'hF || act !== 20'd0) begin
      failures++;
      $display("FAIL reset_first_cycle: state=%0d ctrl=%h expected state=15 ctrl=0", state, act);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_rtype();
    run_instr(6'b000000, "rtype");
  endtask

  task automatic test_back_to_back();
    run_instr(6'b100011, "lw");
    run_instr(6'b101011, "sw");
  endtask

  task automatic test_branch_imm();
    run_instr(6'b000100, "beq");
    run_instr(6'b001100, "andi");
    run_instr(6'b001101, "ori");
    run_instr(6'b001000, "addi");
    run_instr(6'b000010, "j");
  endtask

  task automatic test_illegal();
    run_instr(6'b111111, "illegal");
    run_instr(6'b010101, "illegal2");
  endtask

`ifdef MC_MEM_WAIT_EN
  task automatic test_mem_wait();
    logic [19:0] e;
    int path[3] = '{1, 6, 7};
    opcode = 6'b000000;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      e = exp_vec(0, opcode);
      e[19] = 1'b0;
      e[12] = 1'b0;
      @(negedge clk);
      checks++;
      if (state !== 4'd0 || act !== e) begin
        failures++;
        $display("FAIL fetch_wait%0d: state=%0d ctrl=%h expected state=0 ctrl=%h", i, state, act, e);
      end
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (state !== 4'd0 || act !== exp_vec(0, opcode)) begin
      failures++;
      $display("FAIL fetch_ready: state=%0d ctrl=%h expected state=0 ctrl=%h", state, act, exp_vec(0, opcode));
    end
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (state !== path[i][3:0] || act !== exp_vec(path[i], opcode)) begin
        failures++;
        $display("FAIL wait_tail%0d: state=%0d ctrl=%h expected state=%0d", i, state, act, path[i]);
      end
      @(posedge clk); #1;
    end
  endtask
`endif

  task automatic test_reset_abort();
    int st;
    make_path(6'b100011);
    opcode = 6'b100011;
    for (int i = 0; i < 4; i++) begin
      st = exp_q[i];
      @(negedge clk);
      checks++;
      if (state !== st[3:0] || act !== exp_vec(st, opcode)) begin
        failures++;
        $display("FAIL abort_pre%0d: state=%0d ctrl=%h expected state=%0d", i, state, act, st);
      end
      if (i < 3) begin @(posedge clk); #1; end
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (state !== 4'hF || act !== 20'd0) begin
      failures++;
      $display("FAIL abort_immediate: state=%0d ctrl=%h expected state=15 ctrl=0", state, act);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (state !== 4'hF || act !== 20'd0) begin
      failures++;
      $display("FAIL abort_release: state=%0d ctrl=%h expected state=15 ctrl=0", state, act);
    end
    @(posedge clk); #1;
    run_instr(6'b000000, "post_abort");
  endtask

  task automatic test_random();
    logic [5:0] ops[8] = '{6'b000000, 6'b000010, 6'b000100, 6'b001000,
                           6'b001100, 6'b001101, 6'b100011, 6'b101011};
    logic [31:0] rv;
    logic [5:0]  op;
    for (int n = 0; n < 60; n++) begin
      rv = $urandom();
      if (rv[31:29] == 3'd7) op = rv[5:0];
      else op = ops[rv[10:8]];
      run_instr(op, "random");
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_back_to_back();
    test_branch_imm();
    test_illegal();
`ifdef MC_MEM_WAIT_EN
    test_mem_wait();
`endif
    test_reset_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
